// File: rtl/psdsqrt_param.sv
// Sequential integer square root: non-restoring digit recurrence retiring RB
// root bits per clock, with floor / round-to-nearest result, remainder and flags.
module psdsqrt_param #(
  parameter int XW = 32,
  parameter int RB = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic            rnd,
  input  logic [XW-1:0]   xin,
  output logic            busy,
  output logic            done,
  output logic [XW/2-1:0] sqrt,
  output logic [XW/2:0]   rem,
  output logic            exact,
  output logic            sat
);
  localparam int HW   = XW / 2;
  localparam int RW   = HW + 2;
  localparam int ITER = XW / (2 * RB);
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t                state, state_nx;
  logic [XW-1:0]         xs;
  logic [HW-1:0]         q, q_nx;
  logic signed [RW-1:0]  r, r_nx;
  logic [CW-1:0]         cnt;
  logic                  rmode;
  logic [1:0]            pair;
  logic [HW:0]           rfix;
  logic                  up;

  // One recurrence step per retired bit; the partial remainder stays signed
  // and is corrected only once at the end.
  always_comb begin
    q_nx = q;
    r_nx = r;
    pair = '0;
    for (int i = 0; i < RB; i++) begin
      pair = xs[XW-1-2*i -: 2];
      if (!r_nx[RW-1]) r_nx = {r_nx[RW-3:0], pair} - {q_nx, 2'b01};
      else             r_nx = {r_nx[RW-3:0], pair} + {q_nx, 2'b11};
      q_nx = {q_nx[HW-2:0], ~r_nx[RW-1]};
    end
  end

  assign rfix = r[RW-1] ? (HW+1)'(r + {1'b0, q, 1'b1}) : r[HW:0];
  assign up   = rmode && (rfix > {1'b0, q});
  assign busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (run) state_nx = CALC;
      CALC:    if (cnt == '0) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      xs    <= '0;
      q     <= '0;
      r     <= '0;
      cnt   <= '0;
      rmode <= 1'b0;
      done  <= 1'b0;
      sqrt  <= '0;
      rem   <= '0;
      exact <= 1'b0;
      sat   <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: if (run) begin
          xs    <= xin;
          rmode <= rnd;
          q     <= '0;
          r     <= '0;
          cnt   <= CW'(ITER - 1);
        end
        CALC: begin
          q   <= q_nx;
          r   <= r_nx;
          xs  <= xs << (2 * RB);
          cnt <= cnt - 1'b1;
        end
        FINISH: begin
          done  <= 1'b1;
          rem   <= rfix;
          exact <= (rfix == '0);
          sat   <= up && (&q);
          sqrt  <= (up && !(&q)) ? q + 1'b1 : q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_psdsqrt_param.sv
// Scoreboard bench for psdsqrt_param at (32,1), (16,2) and (64,1): drivers push
// expected results, per-instance monitors pop and compare on each done pulse.
module tb_psdsqrt_param;
  typedef struct {
    longint unsigned sq, rm;
    bit              ex, st;
    longint unsigned due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        run_v [3];
  logic        rnd_v [3];
  logic [63:0] xin_v [3];

  longint unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  exp_t sbA[$], sbB[$], sbC[$];

  logic busyA, doneA, exA, satA; logic [15:0] sqA; logic [16:0] remA;
  logic busyB, doneB, exB, satB; logic [7:0]  sqB; logic [8:0]  remB;
  logic busyC, doneC, exC, satC; logic [31:0] sqC; logic [32:0] remC;

  psdsqrt_param #(.XW(32), .RB(1)) ua (.clock(clock), .reset(reset), .run(run_v[0]),
    .rnd(rnd_v[0]), .xin(xin_v[0][31:0]), .busy(busyA), .done(doneA), .sqrt(sqA),
    .rem(remA), .exact(exA), .sat(satA));
  psdsqrt_param #(.XW(16), .RB(2)) ub (.clock(clock), .reset(reset), .run(run_v[1]),
    .rnd(rnd_v[1]), .xin(xin_v[1][15:0]), .busy(busyB), .done(doneB), .sqrt(sqB),
    .rem(remB), .exact(exB), .sat(satB));
  psdsqrt_param #(.XW(64), .RB(1)) uc (.clock(clock), .reset(reset), .run(run_v[2]),
    .rnd(rnd_v[2]), .xin(xin_v[2]), .busy(busyC), .done(doneC), .sqrt(sqC),
    .rem(remC), .exact(exC), .sat(satC));

  function automatic int xw_of(int u);
    return (u == 0) ? 32 : (u == 1) ? 16 : 64;
  endfunction
  function automatic int iter_of(int u);
    return (u == 0) ? 16 : (u == 1) ? 4 : 32;
  endfunction
  function automatic longint unsigned mask_of(int xw);
    return (xw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xw) - 1);
  endfunction

  // Reference: largest m with m*m <= x by binary search, then apply mode rules.
  function automatic exp_t model(longint unsigned x, bit rn, int xw, longint unsigned due);
    exp_t e;
    longint unsigned lo, hi, mid, q, r, qmax;
    qmax = mask_of(xw / 2);
    lo = 0; hi = qmax;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= x) lo = mid; else hi = mid - 1;
    end
    q = lo; r = x - q * q;
    e.rm = r; e.ex = (r == 0); e.st = 1'b0; e.sq = q; e.due = due;
    if (rn && r > q) begin
      if (q == qmax) e.st = 1'b1;
      else           e.sq = q + 1;
    end
    return e;
  endfunction

  function automatic int sb_size(int u);
    return (u == 0) ? sbA.size() : (u == 1) ? sbB.size() : sbC.size();
  endfunction
  function automatic void sb_push(int u, exp_t e);
    if (u == 0) sbA.push_back(e); else if (u == 1) sbB.push_back(e); else sbC.push_back(e);
  endfunction
  function automatic exp_t sb_pop(int u);
    if (u == 0) return sbA.pop_front();
    if (u == 1) return sbB.pop_front();
    return sbC.pop_front();
  endfunction
  function automatic void sb_clear(int u);
    if (u == 0) sbA.delete(); else if (u == 1) sbB.delete(); else sbC.delete();
  endfunction

  task automatic chk(string nm, longint unsigned got, longint unsigned want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic mon(int u, longint unsigned sq, longint unsigned rm, bit ex, bit st);
    exp_t e;
    if (sb_size(u) == 0) begin
      total++; bad++;
      $display("FAIL unexpected_done unit=%0d got sqrt=%0d want no done", u, sq);
    end else begin
      e = sb_pop(u);
      chk($sformatf("sqrt u%0d", u), sq, e.sq);
      chk($sformatf("rem u%0d", u), rm, e.rm);
      chk($sformatf("exact u%0d", u), ex, e.ex);
      chk($sformatf("sat u%0d", u), st, e.st);
      chk($sformatf("latency u%0d", u), cyc, e.due);
    end
  endtask

  always @(negedge clock) if (doneA === 1'b1) mon(0, sqA, remA, exA, satA);
  always @(negedge clock) if (doneB === 1'b1) mon(1, sqB, remB, exB, satB);
  always @(negedge clock) if (doneC === 1'b1) mon(2, sqC, remC, exC, satC);

  // Drives one run pulse; the expected result is due ITER+2 negedges later.
  task automatic issue(int u, longint unsigned x, bit rn, bit track);
    longint unsigned xm;
    xm = x & mask_of(xw_of(u));
    @(negedge clock);
    run_v[u] = 1'b1; xin_v[u] = xm; rnd_v[u] = rn;
    if (track) sb_push(u, model(xm, rn, xw_of(u), cyc + iter_of(u) + 2));
    @(negedge clock);
    run_v[u] = 1'b0;
  endtask

  task automatic drain(int u, string nm);
    int n = 0;
    while (sb_size(u) != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk(nm, sb_size(u), 0);
    sb_clear(u);
  endtask

  function automatic longint unsigned rand_x(int xw);
    longint unsigned q, x;
    int sel;
    sel = $urandom_range(0, 4);
    q = {$urandom, $urandom} & mask_of(xw / 2);
    case (sel)
      0: x = {$urandom, $urandom};
      1: x = q * q;
      2: x = q * q + q;
      3: x = q * q + q + 1;
      default: x = q * q + 2 * q;
    endcase
    return x & mask_of(xw);
  endfunction

  initial begin
    int bc;
    int n;
    for (int u = 0; u < 3; u++) begin run_v[u] = 1'b0; rnd_v[u] = 1'b0; xin_v[u] = '0; end
    repeat (3) @(negedge clock);
    chk("reset busy", busyA, 0);
    chk("reset done", doneA, 0);
    chk("reset sqrt", sqA, 0);
    chk("reset rem", remA, 0);
    chk("reset exact", exA, 0);
    chk("reset sat", satA, 0);
    reset = 1'b1;

    // Leave non-zero outputs, then reset mid-computation.
    issue(0, 20, 1, 1); drain(0, "drain 20r");
    issue(0, 1000, 0, 0);
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async busy", busyA, 0);
    chk("async sqrt", sqA, 0);
    chk("async rem", remA, 0);
    chk("async exact", exA, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    chk("abandoned busy", busyA, 0);

    issue(0, 144, 0, 1);        drain(0, "drain 144");
    issue(0, 21, 1, 1);         drain(0, "drain 21r");
    issue(0, 31, 1, 1);         drain(0, "drain 31r");
    issue(0, 31, 0, 1);         drain(0, "drain 31f");
    issue(0, 0, 0, 1);          drain(0, "drain 0");
    issue(0, 32'hFFFFFFFF, 0, 1); drain(0, "drain max f");
    issue(0, 32'hFFFFFFFF, 1, 1); drain(0, "drain max r");

    // Second run while busy must be ignored.
    issue(0, 49, 0, 1);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busyA) bc++;
      if (i == 3) begin run_v[0] = 1'b1; xin_v[0] = 64'd100; end
      if (i == 4) run_v[0] = 1'b0;
      @(negedge clock);
    end
    chk("busy cycles", bc, 17);
    drain(0, "drain busy");

    // run held high: restart in the IDLE cycle right after done.
    @(negedge clock);
    run_v[0] = 1'b1; xin_v[0] = 64'd81; rnd_v[0] = 1'b0;
    sb_push(0, model(81, 0, 32, cyc + 18));
    n = 0;
    do begin @(negedge clock); n++; end while (doneA !== 1'b1 && n < 40);
    chk("b2b first done seen", doneA, 1);
    xin_v[0] = 64'd64;
    sb_push(0, model(64, 0, 32, cyc + 18));
    @(negedge clock);
    run_v[0] = 1'b0;
    drain(0, "drain b2b");

    for (int i = 0; i < 20; i++) begin
      issue(0, rand_x(32), 1'($urandom_range(0, 1)), 1);
      drain(0, "drain rand32");
    end

    fork
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < 1000; i++) begin
          issue(1, rand_x(16), 1'(m), 1);
          drain(1, "drain rand16");
        end
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < 700; i++) begin
          issue(2, rand_x(64), 1'(m), 1);
          drain(2, "drain rand64");
        end
    join

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
